// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: state codes,
// opcode values, ALU/mux select codes and the bundled Moore control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore control word decoded from the state register.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives PC, memory, IR, ALU and register-file strobes and selects.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W        = 6,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             pcEn,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic [3:0]       state,
  output logic             illegalOp
);

  state_e state_q, state_d;
  logic   illegal_dec;
  ctrl_t  ctrl, ctrl_g;

  // NOTE: sequential state uses non-blocking assignment; reset is sampled on the clock edge.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = S_R_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            illegal_dec = 1'b1;
            state_d     = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = ALUSRCB_BRANCH;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_IMM;
      end
      S_I_WB:  ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Reset silences every strobe and select combinationally, so an aborted
  // instruction cannot leak a write in the reset cycle.
  assign ctrl_g = reset ? '0 : ctrl;

  assign pcEn      = ctrl_g.pc_write | (ctrl_g.pc_write_cond & (zero ^ ctrl_g.branch_ne));
  assign iorD      = ctrl_g.ior_d;
  assign memRead   = ctrl_g.mem_read;
  assign memWrite  = ctrl_g.mem_write;
  assign irWrite   = ctrl_g.ir_write;
  assign regDst    = ctrl_g.reg_dst;
  assign memToReg  = ctrl_g.mem_to_reg;
  assign regWrite  = ctrl_g.reg_write;
  assign aluSrcA   = ctrl_g.alu_src_a;
  assign aluSrcB   = ctrl_g.alu_src_b;
  assign aluOp     = ctrl_g.alu_op;
  assign pcSource  = ctrl_g.pc_source;
  assign illegalOp = illegal_dec & ~reset;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a non-trapping and a trapping
// instance share stimulus and are compared against a per-instruction path model.
module tb_mc_control_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010,
                         ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
                         SLTI = 6'b001010, BAD = 6'b111111;

  logic       clock = 1'b0;
  logic       reset, zero;
  logic [5:0] opcode;

  logic       n_pc_en, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_dst;
  logic       n_mem_to_reg, n_reg_write, n_alu_src_a, n_illegal;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_source;
  logic [3:0] n_state;
  logic       t_pc_en, t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_dst;
  logic       t_mem_to_reg, t_reg_write, t_alu_src_a, t_illegal;
  logic [1:0] t_alu_src_b, t_alu_op, t_pc_source;
  logic [3:0] t_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: each instance walks the state path of its current instruction.
  int         idx_n, idx_t;
  logic [5:0] op_n, op_t;

  always #5 clock = ~clock;

  mc_control_fsm #(.OPC_W(6), .ILLEGAL_TRAP(1'b0)) u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pcEn(n_pc_en), .iorD(n_iord), .memRead(n_mem_read), .memWrite(n_mem_write),
    .irWrite(n_ir_write), .regDst(n_reg_dst), .memToReg(n_mem_to_reg),
    .regWrite(n_reg_write), .aluSrcA(n_alu_src_a), .aluSrcB(n_alu_src_b),
    .aluOp(n_alu_op), .pcSource(n_pc_source), .state(n_state), .illegalOp(n_illegal)
  );

  mc_control_fsm #(.OPC_W(6), .ILLEGAL_TRAP(1'b1)) u_trap (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pcEn(t_pc_en), .iorD(t_iord), .memRead(t_mem_read), .memWrite(t_mem_write),
    .irWrite(t_ir_write), .regDst(t_reg_dst), .memToReg(t_mem_to_reg),
    .regWrite(t_reg_write), .aluSrcA(t_alu_src_a), .aluSrcB(t_alu_src_b),
    .aluOp(t_alu_op), .pcSource(t_pc_source), .state(t_state), .illegalOp(t_illegal)
  );

  function automatic bit is_imm(input logic [5:0] op);
    return op == ADDI || op == ANDI || op == ORI || op == SLTI;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == BNE || op == JMP || is_imm(op);
  endfunction

  function automatic int path_len(input logic [5:0] op, input bit trap);
    if (op == LW) return 5;
    if (op == SW || op == RT || is_imm(op)) return 4;
    if (op == BEQ || op == BNE || op == JMP) return 3;
    return trap ? 3 : 2;
  endfunction

  function automatic logic [3:0] path_state(input logic [5:0] op, input bit trap, input int pos);
    if (pos <= 1) return 4'(pos);
    if (pos == 2) begin
      if (op == LW || op == SW)   return 4'd2;
      if (op == RT)               return 4'd6;
      if (op == BEQ || op == BNE) return 4'd8;
      if (op == JMP)              return 4'd9;
      if (is_imm(op))             return 4'd10;
      return trap ? 4'd12 : 4'd0;
    end
    if (pos == 3) begin
      if (op == LW) return 4'd3;
      if (op == SW) return 4'd5;
      if (op == RT) return 4'd7;
      return 4'd11;
    end
    return 4'd4;
  endfunction

  function automatic int advance(input logic [5:0] op, input bit trap, input int pos);
    int len = path_len(op, trap);
    if (pos + 1 < len) return pos + 1;
    return (trap && !is_legal(op)) ? pos : 0;
  endfunction

  // Packed {pcEn,iorD,memRead,memWrite,irWrite,regDst,memToReg,regWrite,
  //         aluSrcA,aluSrcB,aluOp,pcSource,illegalOp}
  function automatic logic [15:0] exp_outs(input logic [5:0] op, input int pos,
                                           input bit z, input bit rst);
    bit lw = (op == LW), sw = (op == SW), rt = (op == RT), jmp = (op == JMP);
    bit br = (op == BEQ || op == BNE), im = is_imm(op);
    logic [1:0] srcb, aop, psrc;
    if (rst) return 16'h0;
    srcb = (pos == 0) ? 2'd1 : (pos == 1) ? 2'd3 : (pos == 2 && (lw || sw || im)) ? 2'd2 : 2'd0;
    aop  = (pos != 2) ? 2'd0 : rt ? 2'd2 : br ? 2'd1 : im ? 2'd3 : 2'd0;
    psrc = (pos != 2) ? 2'd0 : br ? 2'd1 : jmp ? 2'd2 : 2'd0;
    return {pos == 0 || (jmp && pos == 2) || (br && pos == 2 && (z ^ (op == BNE))),
            (lw || sw) && pos == 3,
            pos == 0 || (lw && pos == 3),
            sw && pos == 3,
            pos == 0,
            rt && pos == 3,
            lw && pos == 4,
            (lw && pos == 4) || ((rt || im) && pos == 3),
            pos == 2 && (lw || sw || rt || br || im),
            srcb, aop, psrc,
            !is_legal(op) && pos == 1};
  endfunction

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%04h expected=%04h", tag, observed, expected);
    end
  endtask

  // One clock: pick the opcode when fetching, apply inputs, compare, advance model.
  task automatic cycle(input bit rst, input logic [5:0] op, input bit z);
    @(posedge clock);
    #1;
    if (idx_n == 0) begin
      opcode = op;
      op_n   = op;
    end
    if (idx_t == 0) op_t = op;
    zero  = z;
    reset = rst;
    #1;
    check("dut_state", {12'h0, n_state}, {12'h0, path_state(op_n, 1'b0, idx_n)});
    check("dut_outs",
          {n_pc_en, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg,
           n_reg_write, n_alu_src_a, n_alu_src_b, n_alu_op, n_pc_source, n_illegal},
          exp_outs(op_n, idx_n, z, rst));
    check("trap_state", {12'h0, t_state}, {12'h0, path_state(op_t, 1'b1, idx_t)});
    check("trap_outs",
          {t_pc_en, t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_dst, t_mem_to_reg,
           t_reg_write, t_alu_src_a, t_alu_src_b, t_alu_op, t_pc_source, t_illegal},
          (path_state(op_t, 1'b1, idx_t) == 4'd12) ? 16'h0 : exp_outs(op_t, idx_t, z, rst));
    if (rst) begin
      idx_n = 0;
      idx_t = 0;
    end else begin
      idx_n = advance(op_n, 1'b0, idx_n);
      idx_t = advance(op_t, 1'b1, idx_t);
    end
  endtask

  task automatic run(input logic [5:0] op, input bit z, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, op, z);
  endtask

  logic [5:0] legal_ops [11];

  initial begin
    legal_ops = '{LW, SW, RT, BEQ, BNE, JMP, ADDI, ANDI, ORI, SLTI, LW};
    reset  = 1'b1;
    zero   = 1'b0;
    opcode = RT;
    op_n   = RT;
    op_t   = RT;
    idx_n  = 0;
    idx_t  = 0;

    // Before the first edge the state is unknown but strobes are already gated.
    #2;
    check("reset_outs_pre_edge",
          {n_pc_en, n_mem_read, n_mem_write, n_ir_write, n_reg_write, n_illegal, 10'h0}, 16'h0);

    // Reset spans three edges, then the first fetch.
    cycle(1'b1, RT, 1'b0);
    cycle(1'b1, RT, 1'b0);
    run(LW, 1'b0, 5);
    run(RT, 1'b0, 4);
    run(SW, 1'b0, 4);
    run(BEQ, 1'b1, 3);
    run(BEQ, 1'b0, 3);
    run(BNE, 1'b0, 3);
    run(BNE, 1'b1, 3);
    run(JMP, 1'b0, 3);
    run(ADDI, 1'b0, 4);
    run(SLTI, 1'b1, 4);

    // Illegal opcode: one instance returns to fetch, the trapping one halts.
    run(BAD, 1'b0, 2);
    run(LW, 1'b0, 5);
    run(ORI, 1'b0, 4);
    cycle(1'b1, RT, 1'b0);

    // Abort an R-type in its execute state; no register write may follow.
    run(RT, 1'b0, 2);
    cycle(1'b1, RT, 1'b0);
    run(ANDI, 1'b0, 4);

    // Randomized traffic with occasional illegal opcodes and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int         pick = $urandom_range(0, 11);
      op = (pick == 11) ? 6'($urandom) : legal_ops[pick];
      cycle(($urandom_range(0, 39) == 0), op, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
